mcn_load_receiver: RTL and testbench

//  Receive end of the cluster load/config protocol: captures scanned multicast IDs, matches per-cycle
//  (tag_y, tag_x) targets against them, and emits registered per-PE scratchpad writes with per-PE address

---
 rtl/mcn_load_receiver_if.sv | 42 ++++
 rtl/mcn_load_receiver.sv | 124 ++++++++++++
 tb/tb_mcn_load_receiver.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mcn_load_receiver_if.sv
// Load/config bus between a load controller (master) and one mcn_load_receiver (slave).
// Protocol: no back-pressure. A word is offered whenever enable_i is high and both tags are non-idle.
interface mcn_load_receiver_if #(
  parameter int numPeX   = 3,
  parameter int numPeY   = 3,
  parameter int dataSize = 8,
  parameter int idSize   = 8,
  parameter int spadNReg = 16
);
  localparam int P  = numPeX * numPeY;
  localparam int AW = $clog2(spadNReg);

  logic                enable_i;
  logic [idSize-1:0]   id_scan_i;
  logic                id_wren_i;
  logic                load_clear_i;
  logic [7:0]          count_i;
  logic [idSize-1:0]   tag_target_y_i;
  logic [idSize-1:0]   tag_target_x_i;
  logic [dataSize-1:0] data_i;
  logic [P-1:0]        pe_wr_en_o;
  logic [P*AW-1:0]     pe_wr_addr_o;
  logic [dataSize-1:0] pe_wr_data_o;
  logic                id_valid_o;
  logic                load_done_o;
  logic                overflow_o;
  logic [1:0]          dbg_state;

  modport master (
    output enable_i, id_scan_i, id_wren_i, load_clear_i, count_i,
           tag_target_y_i, tag_target_x_i, data_i,
    input  pe_wr_en_o, pe_wr_addr_o, pe_wr_data_o, id_valid_o, load_done_o,
           overflow_o, dbg_state
  );

  modport slave (
    input  enable_i, id_scan_i, id_wren_i, load_clear_i, count_i,
           tag_target_y_i, tag_target_x_i, data_i,
    output pe_wr_en_o, pe_wr_addr_o, pe_wr_data_o, id_valid_o, load_done_o,
           overflow_o, dbg_state
  );
endinterface

// File: rtl/mcn_load_receiver.sv
// Receive end of the cluster load protocol: scanned multicast IDs, tag matching and
// registered per-PE scratchpad writes with per-PE address pointers.
module mcn_load_receiver #(
  parameter int numPeX   = 3,
  parameter int numPeY   = 3,
  parameter int dataSize = 8,
  parameter int idSize   = 8,
  parameter int spadNReg = 16
) (
  input logic                clk,
  input logic                rst,
  mcn_load_receiver_if.slave bus
);
  localparam int P  = numPeX * numPeY;
  localparam int L  = numPeY + P;
  localparam int AW = $clog2(spadNReg);
  localparam int PW = $clog2(spadNReg + 1);
  localparam logic [idSize-1:0] IDLE = '1;

  typedef enum logic [1:0] {UNCONF = 2'd0, LOAD = 2'd1, DONE = 2'd2} state_t;

  state_t state, state_next;

  logic [L-1:0][idSize-1:0]      sr;
  logic [numPeY-1:0][idSize-1:0] row_id;
  logic [P-1:0][idSize-1:0]      col_id;
  logic [P-1:0][PW-1:0]          ptr;
  logic                          id_valid;
  logic                          overflow;
  logic [P-1:0]                  wr_en;
  logic [P-1:0][AW-1:0]          wr_addr;
  logic [dataSize-1:0]           wr_data;

  logic [PW-1:0] eff_c;
  logic [P-1:0]  pe_on, match, at_limit;
  logic          tag_ok, commit, clear, restart, all_done;

  always_comb begin
    commit   = bus.enable_i & bus.id_wren_i;
    clear    = bus.enable_i & bus.load_clear_i & (state != UNCONF);
    restart  = commit | clear;
    tag_ok   = (bus.tag_target_y_i != IDLE) && (bus.tag_target_x_i != IDLE);
    eff_c    = (32'(bus.count_i) > spadNReg) ? PW'(spadNReg) : PW'(bus.count_i);
    pe_on    = '0;
    match    = '0;
    at_limit = '0;
    for (int i = 0; i < P; i++) begin
      pe_on[i]    = (row_id[i / numPeX] != IDLE) && (col_id[i] != IDLE);
      // A restart in the same cycle swallows the word without flagging overflow.
      match[i]    = bus.enable_i & id_valid & tag_ok & ~restart &
                    (row_id[i / numPeX] == bus.tag_target_y_i) &
                    (col_id[i] == bus.tag_target_x_i);
      at_limit[i] = (ptr[i] >= eff_c);
    end
    all_done = &(at_limit | ~pe_on);
  end

  always_comb begin
    state_next = state;
    if (restart) begin
      state_next = LOAD;
    end else if (bus.enable_i) begin
      case (state)
        LOAD:    if (all_done)  state_next = DONE;
        DONE:    if (!all_done) state_next = LOAD;
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= UNCONF;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr       <= '1;
      row_id   <= '1;
      col_id   <= '1;
      ptr      <= '0;
      id_valid <= 1'b0;
      overflow <= 1'b0;
      wr_en    <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      wr_en <= '0;
      if (bus.enable_i) begin
        sr <= {bus.id_scan_i, sr[L-1:1]};
        if (commit) begin
          row_id   <= sr[numPeY-1:0];
          col_id   <= sr[L-1:numPeY];
          id_valid <= 1'b1;
        end
        if (restart) begin
          ptr      <= '0;
          overflow <= 1'b0;
        end else begin
          for (int i = 0; i < P; i++) begin
            if (match[i]) begin
              if (!at_limit[i]) begin
                wr_en[i]   <= 1'b1;
                wr_addr[i] <= ptr[i][AW-1:0];
                ptr[i]     <= ptr[i] + PW'(1);
              end else begin
                overflow <= 1'b1;
              end
            end
          end
          if (|(match & ~at_limit)) wr_data <= bus.data_i;
        end
      end
    end
  end

  assign bus.pe_wr_en_o   = wr_en;
  assign bus.pe_wr_addr_o = wr_addr;
  assign bus.pe_wr_data_o = wr_data;
  assign bus.id_valid_o   = id_valid;
  assign bus.load_done_o  = (state == DONE);
  assign bus.overflow_o   = overflow;
  assign bus.dbg_state    = state;
endmodule

// File: tb/tb_mcn_load_receiver.sv
// Directed bench for mcn_load_receiver: targeted, multicast, overflow, disabled PEs,
// enable gaps, load clear and asynchronous reset mid-load.
module tb_mcn_load_receiver;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mcn_load_receiver_if bus ();

  mcn_load_receiver dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] ids [12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.enable_i       = 1'b1;
    bus.id_wren_i      = 1'b0;
    bus.load_clear_i   = 1'b0;
    bus.id_scan_i      = 8'hFF;
    bus.tag_target_y_i = 8'hFF;
    bus.tag_target_x_i = 8'hFF;
    bus.data_i         = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic scan_and_commit();
    for (int i = 0; i < 12; i++) begin
      bus.id_scan_i = ids[i];
      step();
    end
    bus.id_scan_i = 8'hFF;
    bus.id_wren_i = 1'b1;
    step();
    bus.id_wren_i = 1'b0;
  endtask

  task automatic send(input logic [7:0] ty, input logic [7:0] tx, input logic [7:0] d);
    bus.tag_target_y_i = ty;
    bus.tag_target_x_i = tx;
    bus.data_i         = d;
    step();
    bus.tag_target_y_i = 8'hFF;
    bus.tag_target_x_i = 8'hFF;
  endtask

  task automatic cfg_grid();
    ids = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2};
  endtask

  task automatic test_reset();
    bus.count_i = 8'd3;
    do_reset();
    tests_run++; if (bus.pe_wr_en_o !== 9'h000) begin tests_failed++; $display("FAIL reset_wr_en got %h want 000", bus.pe_wr_en_o); end
    tests_run++; if (bus.pe_wr_addr_o !== 36'h0) begin tests_failed++; $display("FAIL reset_wr_addr got %h want 0", bus.pe_wr_addr_o); end
    tests_run++; if (bus.pe_wr_data_o !== 8'h00) begin tests_failed++; $display("FAIL reset_wr_data got %h want 00", bus.pe_wr_data_o); end
    tests_run++; if ({bus.id_valid_o, bus.load_done_o, bus.overflow_o} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags got %b want 000", {bus.id_valid_o, bus.load_done_o, bus.overflow_o}); end
    tests_run++; if (bus.dbg_state !== 2'd0) begin tests_failed++; $display("FAIL reset_state got %0d want 0", bus.dbg_state); end
    send(8'd0, 8'd0, 8'h33);
    tests_run++; if (bus.pe_wr_en_o !== 9'h000) begin tests_failed++; $display("FAIL unconf_no_write got %h want 000", bus.pe_wr_en_o); end
  endtask

  task automatic test_single_target();
    do_reset();
    cfg_grid();
    bus.count_i = 8'd3;
    scan_and_commit();
    tests_run++; if (bus.id_valid_o !== 1'b1) begin tests_failed++; $display("FAIL commit_id_valid got %b want 1", bus.id_valid_o); end
    tests_run++; if (bus.dbg_state !== 2'd1) begin tests_failed++; $display("FAIL commit_state got %0d want 1", bus.dbg_state); end
    tests_run++; if (bus.pe_wr_en_o !== 9'h000) begin tests_failed++; $display("FAIL commit_no_write got %h want 000", bus.pe_wr_en_o); end
    for (int w = 0; w < 3; w++) begin
      send(8'd1, 8'd2, 8'(5 + w));
      tests_run++; if (bus.pe_wr_en_o !== 9'h020) begin tests_failed++; $display("FAIL single_en[%0d] got %h want 020", w, bus.pe_wr_en_o); end
      tests_run++; if (bus.pe_wr_addr_o[5*AW +: AW] !== 4'(w)) begin tests_failed++; $display("FAIL single_addr[%0d] got %0d want %0d", w, bus.pe_wr_addr_o[5*AW +: AW], w); end
      tests_run++; if (bus.pe_wr_data_o !== 8'(5 + w)) begin tests_failed++; $display("FAIL single_data[%0d] got %0d want %0d", w, bus.pe_wr_data_o, 5 + w); end
    end
    step();
    tests_run++; if (bus.pe_wr_en_o !== 9'h000) begin tests_failed++; $display("FAIL single_quiet got %h want 000", bus.pe_wr_en_o); end
    tests_run++; if (bus.pe_wr_data_o !== 8'd7) begin tests_failed++; $display("FAIL single_data_hold got %0d want 7", bus.pe_wr_data_o); end
    tests_run++; if (bus.load_done_o !== 1'b0) begin tests_failed++; $display("FAIL single_not_done got %b want 0", bus.load_done_o); end
  endtask

  task automatic test_multicast();
    logic [8:0] exp_en;
    do_reset();
    ids = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    bus.count_i = 8'd3;
    scan_and_commit();
    for (int r = 0; r < 3; r++) begin
      exp_en = 9'b111 << (3 * r);
      for (int w = 0; w < 3; w++) begin
        send(8'(r), 8'd0, 8'(16 * r + w));
        tests_run++; if (bus.pe_wr_en_o !== exp_en) begin tests_failed++; $display("FAIL mc_en[%0d][%0d] got %h want %h", r, w, bus.pe_wr_en_o, exp_en); end
        for (int x = 0; x < 3; x++) begin
          tests_run++; if (bus.pe_wr_addr_o[(3*r+x)*AW +: AW] !== 4'(w)) begin tests_failed++; $display("FAIL mc_addr[%0d][%0d] got %0d want %0d", r, x, bus.pe_wr_addr_o[(3*r+x)*AW +: AW], w); end
        end
        tests_run++; if (bus.pe_wr_data_o !== 8'(16 * r + w)) begin tests_failed++; $display("FAIL mc_data[%0d][%0d] got %h want %h", r, w, bus.pe_wr_data_o, 16 * r + w); end
      end
    end
    tests_run++; if (bus.load_done_o !== 1'b0) begin tests_failed++; $display("FAIL mc_done_early got %b want 0", bus.load_done_o); end
    step();
    tests_run++; if (bus.load_done_o !== 1'b1) begin tests_failed++; $display("FAIL mc_done got %b want 1", bus.load_done_o); end
    tests_run++; if (bus.dbg_state !== 2'd2) begin tests_failed++; $display("FAIL mc_state got %0d want 2", bus.dbg_state); end
  endtask

  task automatic test_overflow();
    do_reset();
    cfg_grid();
    bus.count_i = 8'd3;
    scan_and_commit();
    for (int w = 0; w < 4; w++) begin
      send(8'd0, 8'd0, 8'(8'h40 + w));
      if (w < 3) begin
        tests_run++; if (bus.pe_wr_en_o !== 9'h001) begin tests_failed++; $display("FAIL ovf_en[%0d] got %h want 001", w, bus.pe_wr_en_o); end
        tests_run++; if (bus.pe_wr_addr_o[0 +: AW] !== 4'(w)) begin tests_failed++; $display("FAIL ovf_addr[%0d] got %0d want %0d", w, bus.pe_wr_addr_o[0 +: AW], w); end
        tests_run++; if (bus.overflow_o !== 1'b0) begin tests_failed++; $display("FAIL ovf_early[%0d] got %b want 0", w, bus.overflow_o); end
      end else begin
        tests_run++; if (bus.pe_wr_en_o !== 9'h000) begin tests_failed++; $display("FAIL ovf_drop got %h want 000", bus.pe_wr_en_o); end
        tests_run++; if (bus.overflow_o !== 1'b1) begin tests_failed++; $display("FAIL ovf_flag got %b want 1", bus.overflow_o); end
        tests_run++; if (bus.pe_wr_data_o !== 8'h42) begin tests_failed++; $display("FAIL ovf_data_hold got %h want 42", bus.pe_wr_data_o); end
      end
    end
    step();
    step();
    tests_run++; if (bus.overflow_o !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky got %b want 1", bus.overflow_o); end
  endtask

  task automatic test_disabled_pe();
    do_reset();
    ids = '{8'd0, 8'd1, 8'd255, 8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2};
    bus.count_i = 8'd2;
    scan_and_commit();
    for (int r = 0; r < 2; r++) begin
      for (int x = 0; x < 3; x++) begin
        for (int w = 0; w < 2; w++) begin
          send(8'(r), 8'(x), 8'(r * 8 + x * 2 + w));
          tests_run++; if (bus.pe_wr_en_o !== (9'b1 << (3 * r + x))) begin tests_failed++; $display("FAIL dis_en[%0d][%0d] got %h want %h", r, x, bus.pe_wr_en_o, 9'b1 << (3 * r + x)); end
          tests_run++; if (bus.pe_wr_addr_o[(3*r+x)*AW +: AW] !== 4'(w)) begin tests_failed++; $display("FAIL dis_addr[%0d][%0d] got %0d want %0d", r, x, bus.pe_wr_addr_o[(3*r+x)*AW +: AW], w); end
        end
      end
    end
    tests_run++; if (bus.load_done_o !== 1'b0) begin tests_failed++; $display("FAIL dis_done_early got %b want 0", bus.load_done_o); end
    step();
    tests_run++; if (bus.load_done_o !== 1'b1) begin tests_failed++; $display("FAIL dis_done got %b want 1", bus.load_done_o); end
    send(8'd255, 8'd0, 8'h55);
    tests_run++; if (bus.pe_wr_en_o !== 9'h000) begin tests_failed++; $display("FAIL dis_idle_tag got %h want 000", bus.pe_wr_en_o); end
    send(8'd2, 8'd0, 8'h56);
    tests_run++; if (bus.pe_wr_en_o !== 9'h000) begin tests_failed++; $display("FAIL dis_row2 got %h want 000", bus.pe_wr_en_o); end
    tests_run++; if (bus.overflow_o !== 1'b0) begin tests_failed++; $display("FAIL dis_no_ovf got %b want 0", bus.overflow_o); end
  endtask

  task automatic test_enable_gaps();
    do_reset();
    cfg_grid();
    bus.count_i = 8'd4;
    scan_and_commit();
    send(8'd1, 8'd1, 8'h11);
    send(8'd1, 8'd1, 8'h12);
    tests_run++; if (bus.pe_wr_addr_o[4*AW +: AW] !== 4'd1) begin tests_failed++; $display("FAIL gap_addr_pre got %0d want 1", bus.pe_wr_addr_o[4*AW +: AW]); end
    bus.enable_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      send(8'd1, 8'd1, 8'h99);
      tests_run++; if (bus.pe_wr_en_o !== 9'h000) begin tests_failed++; $display("FAIL gap_disabled[%0d] got %h want 000", c, bus.pe_wr_en_o); end
    end
    tests_run++; if (bus.pe_wr_data_o !== 8'h12) begin tests_failed++; $display("FAIL gap_data_hold got %h want 12", bus.pe_wr_data_o); end
    bus.enable_i = 1'b1;
    send(8'd255, 8'd1, 8'h98);
    tests_run++; if (bus.pe_wr_en_o !== 9'h000) begin tests_failed++; $display("FAIL gap_idle got %h want 000", bus.pe_wr_en_o); end
    for (int w = 2; w < 4; w++) begin
      send(8'd1, 8'd1, 8'(8'h11 + w));
      tests_run++; if (bus.pe_wr_en_o !== 9'h010) begin tests_failed++; $display("FAIL gap_en[%0d] got %h want 010", w, bus.pe_wr_en_o); end
      tests_run++; if (bus.pe_wr_addr_o[4*AW +: AW] !== 4'(w)) begin tests_failed++; $display("FAIL gap_addr[%0d] got %0d want %0d", w, bus.pe_wr_addr_o[4*AW +: AW], w); end
    end
  endtask

  task automatic test_load_clear();
    bus.load_clear_i = 1'b1;
    send(8'd1, 8'd1, 8'h20);
    bus.load_clear_i = 1'b0;
    tests_run++; if (bus.pe_wr_en_o !== 9'h000) begin tests_failed++; $display("FAIL clr_drop got %h want 000", bus.pe_wr_en_o); end
    tests_run++; if (bus.overflow_o !== 1'b0) begin tests_failed++; $display("FAIL clr_no_ovf got %b want 0", bus.overflow_o); end
    send(8'd1, 8'd1, 8'h21);
    tests_run++; if (bus.pe_wr_en_o !== 9'h010) begin tests_failed++; $display("FAIL clr_en got %h want 010", bus.pe_wr_en_o); end
    tests_run++; if (bus.pe_wr_addr_o[4*AW +: AW] !== 4'd0) begin tests_failed++; $display("FAIL clr_addr got %0d want 0", bus.pe_wr_addr_o[4*AW +: AW]); end
    for (int c = 0; c < 12; c++) step();
    bus.id_wren_i = 1'b1;
    send(8'd1, 8'd1, 8'h22);
    bus.id_wren_i = 1'b0;
    tests_run++; if (bus.pe_wr_en_o !== 9'h000) begin tests_failed++; $display("FAIL wren_drop got %h want 000", bus.pe_wr_en_o); end
    step();
    tests_run++; if (bus.load_done_o !== 1'b1) begin tests_failed++; $display("FAIL no_pe_done got %b want 1", bus.load_done_o); end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    cfg_grid();
    bus.count_i = 8'd3;
    scan_and_commit();
    send(8'd1, 8'd2, 8'h61);
    send(8'd1, 8'd2, 8'h62);
    tests_run++; if (bus.pe_wr_addr_o[5*AW +: AW] !== 4'd1) begin tests_failed++; $display("FAIL rst_pre_addr got %0d want 1", bus.pe_wr_addr_o[5*AW +: AW]); end
    #2;
    rst = 1'b1;
    #1;
    tests_run++; if (bus.pe_wr_en_o !== 9'h000) begin tests_failed++; $display("FAIL rst_mid_en got %h want 000", bus.pe_wr_en_o); end
    tests_run++; if (bus.pe_wr_data_o !== 8'h00) begin tests_failed++; $display("FAIL rst_mid_data got %h want 00", bus.pe_wr_data_o); end
    tests_run++; if ({bus.id_valid_o, bus.load_done_o, bus.overflow_o} !== 3'b000) begin tests_failed++; $display("FAIL rst_mid_flags got %b want 000", {bus.id_valid_o, bus.load_done_o, bus.overflow_o}); end
    step();
    rst = 1'b0;
    step();
    send(8'd1, 8'd2, 8'h77);
    tests_run++; if (bus.pe_wr_en_o !== 9'h000) begin tests_failed++; $display("FAIL rst_no_write got %h want 000", bus.pe_wr_en_o); end
    scan_and_commit();
    send(8'd1, 8'd2, 8'h78);
    tests_run++; if (bus.pe_wr_en_o !== 9'h020) begin tests_failed++; $display("FAIL rescan_en got %h want 020", bus.pe_wr_en_o); end
    tests_run++; if (bus.pe_wr_addr_o[5*AW +: AW] !== 4'd0) begin tests_failed++; $display("FAIL rescan_addr got %0d want 0", bus.pe_wr_addr_o[5*AW +: AW]); end
  endtask

  initial begin
    idle_inputs();
    bus.count_i = 8'd0;
    test_reset();
    test_single_target();
    test_multicast();
    test_overflow();
    test_disabled_pe();
    test_enable_gaps();
    test_load_clear();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
